// File: rtl/mpmc10_pkg.sv
// rtl/mpmc10_pkg.sv - shared state encodings and default geometry for the stream read cache
package mpmc10_pkg;

    typedef enum logic {
        IDLE,
        FILL
    } fill_state_t;

    typedef enum logic {
        MIDLE,
        MREQ
    } miss_state_t;

    localparam int DEF_DW    = 128;
    localparam int DEF_AW    = 32;
    localparam int DEF_LINES = 8;
    localparam int DEF_BEATS = 64;

endpackage

// File: rtl/mpmc11_strm_cache_ram.sv
// rtl/mpmc11_strm_cache_ram.sv - single-clock simple dual-port line storage, registered read
module mpmc11_strm_cache_ram #(
    parameter int DW    = 128,
    parameter int ABITS = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [ABITS-1:0] wa,
    input  logic [DW-1:0]    wd,
    input  logic             re,
    input  logic [ABITS-1:0] ra,
    output logic [DW-1:0]    rdata
);

    logic [DW-1:0] mem [2**ABITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
    end

    // Output register only loads on a read, so the last read word is held between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[ra];
        end
    end

endmodule

// File: rtl/mpmc11_strm_read_cache.sv
// rtl/mpmc11_strm_read_cache.sv - streaming-fill read cache with line refill request handshake
module mpmc11_strm_read_cache
    import mpmc10_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int AW    = DEF_AW,
    parameter int LINES = DEF_LINES,
    parameter int BEATS = DEF_BEATS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr,
    input  logic [AW-1:0] wadr,
    input  logic [DW-1:0] wdat,
    input  logic          inv,
    input  logic          inv_all,
    input  logic          rd,
    input  logic [AW-1:0] radr,
    output logic [DW-1:0] rdat,
    output logic          rvalid,
    output logic          hit,
    output logic          miss_req,
    output logic [AW-1:0] miss_adr,
    input  logic          miss_ack
);

    localparam int OW = $clog2(DW / 8);
    localparam int BW = $clog2(BEATS);
    localparam int LW = $clog2(LINES);
    localparam int TW = AW - OW - BW - LW;

    logic [BW-1:0] w_word, r_word;
    logic [LW-1:0] w_line, r_line;
    logic [TW-1:0] w_tag, r_tag;

    assign w_word = wadr[OW+BW-1:OW];
    assign w_line = wadr[OW+BW+LW-1:OW+BW];
    assign w_tag  = wadr[AW-1:OW+BW+LW];
    assign r_word = radr[OW+BW-1:OW];
    assign r_line = radr[OW+BW+LW-1:OW+BW];
    assign r_tag  = radr[AW-1:OW+BW+LW];

    logic unused_ok;
    assign unused_ok = ^{wadr[OW-1:0], radr[OW-1:0]};

    fill_state_t   fstate, fstate_n;
    miss_state_t   mstate, mstate_n;
    logic [BW-1:0] cnt, cnt_n;
    logic [LW-1:0] fl, fl_n;
    logic [TW-1:0] ft, ft_n;
    logic [TW-1:0] tags [LINES];
    logic [TW-1:0] tag_n [LINES];
    logic [LINES-1:0] vbit, vbit_n;
    logic [LW-1:0] ra_line;
    logic [TW-1:0] ra_tag;
    logic [AW-1:0] miss_adr_n;
    logic          same_fill;

    mpmc11_strm_cache_ram #(
        .DW    (DW),
        .ABITS (LW + BW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr),
        .wa    ({w_line, w_word}),
        .wd    (wdat),
        .re    (rd),
        .ra    ({r_line, r_word}),
        .rdata (rdat)
    );

    // Fill tracking; invalidations are applied last so they override a completing beat.
    always_comb begin
        fstate_n = fstate;
        cnt_n    = cnt;
        fl_n     = fl;
        ft_n     = ft;
        vbit_n   = vbit;
        tag_n    = tags;
        if (wr) begin
            if (fstate == FILL && w_line == fl && w_tag == ft && w_word == cnt) begin
                if (w_word == BW'(BEATS - 1)) begin
                    tag_n[fl]  = ft;
                    vbit_n[fl] = 1'b1;
                    fstate_n   = IDLE;
                end else begin
                    cnt_n = cnt + BW'(1);
                end
            end else if (w_word == '0) begin
                fstate_n       = FILL;
                cnt_n          = BW'(1);
                fl_n           = w_line;
                ft_n           = w_tag;
                vbit_n[w_line] = 1'b0;
            end else begin
                fstate_n = IDLE;
            end
        end
        if (inv) begin
            vbit_n[w_line] = 1'b0;
            if (fstate == FILL && w_line == fl) begin
                fstate_n = IDLE;
            end
        end
        if (inv_all) begin
            vbit_n = '0;
            if (fstate == FILL) begin
                fstate_n = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fstate <= IDLE;
            cnt    <= '0;
            fl     <= '0;
            ft     <= '0;
            vbit   <= '0;
            for (int i = 0; i < LINES; i++) begin
                tags[i] <= '0;
            end
        end else begin
            fstate <= fstate_n;
            cnt    <= cnt_n;
            fl     <= fl_n;
            ft     <= ft_n;
            vbit   <= vbit_n;
            tags   <= tag_n;
        end
    end

    // Hit is judged against the tag/valid state as it stands after the read edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid  <= 1'b0;
            hit     <= 1'b0;
            ra_line <= '0;
            ra_tag  <= '0;
        end else begin
            rvalid <= rd;
            if (rd) begin
                hit     <= vbit_n[r_line] && (tag_n[r_line] == r_tag);
                ra_line <= r_line;
                ra_tag  <= r_tag;
            end
        end
    end

    assign same_fill = (fstate == FILL) && (ra_line == fl) && (ra_tag == ft);

    always_comb begin
        mstate_n   = mstate;
        miss_adr_n = miss_adr;
        case (mstate)
            MIDLE: begin
                if (rvalid && !hit && !same_fill) begin
                    mstate_n   = MREQ;
                    miss_adr_n = {ra_tag, ra_line, {(OW + BW){1'b0}}};
                end
            end
            MREQ: begin
                if (miss_ack) begin
                    mstate_n = MIDLE;
                end
            end
            default: mstate_n = MIDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstate   <= MIDLE;
            miss_adr <= '0;
        end else begin
            mstate   <= mstate_n;
            miss_adr <= miss_adr_n;
        end
    end

    assign miss_req = (mstate == MREQ);

endmodule

// File: tb/tb_mpmc11_strm_read_cache.sv
// tb/tb_mpmc11_strm_read_cache.sv - scoreboard bench for the stream read cache
module tb_mpmc11_strm_read_cache;

    localparam int DW = 128;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr, inv, inv_all, rd, miss_ack;
    logic [AW-1:0] wadr, radr, miss_adr;
    logic [DW-1:0] wdat, rdat;
    logic          rvalid, hit, miss_req;

    typedef struct {
        logic [DW-1:0] d;
        logic          h;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_reads = 0;
    int   rv_cnt = 0;

    mpmc11_strm_read_cache dut (
        .clk      (clk),
        .rst      (rst),
        .wr       (wr),
        .wadr     (wadr),
        .wdat     (wdat),
        .inv      (inv),
        .inv_all  (inv_all),
        .rd       (rd),
        .radr     (radr),
        .rdat     (rdat),
        .rvalid   (rvalid),
        .hit      (hit),
        .miss_req (miss_req),
        .miss_adr (miss_adr),
        .miss_ack (miss_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string n, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rvalid) begin
            rv_cnt++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rvalid actual=1 expected=0");
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rdat", rdat, e.d);
                chk("hit", {127'd0, hit}, {127'd0, e.h});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_beat(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic ia);
        wr = 1'b1; wadr = a; wdat = d; inv_all = ia;
        tick();
        wr = 1'b0; inv_all = 1'b0;
    endtask

    task automatic fill(input logic [AW-1:0] base, input logic [DW-1:0] dbase,
                        input int first, input int last, input int skip);
        for (int i = first; i <= last; i++) begin
            if (i != skip) wr_beat(base + AW'(16 * i), dbase + DW'(i), 1'b0);
        end
    endtask

    task automatic rd_req(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic h);
        exp_t e;
        e.d = d; e.h = h;
        q.push_back(e);
        n_reads++;
        rd = 1'b1; radr = a;
        tick();
        rd = 1'b0;
    endtask

    task automatic ack_miss(input logic [AW-1:0] a);
        int k = 0;
        while (!miss_req && k < 10) begin
            tick();
            k++;
        end
        chk("miss_raise", {127'd0, miss_req}, 128'd1);
        chk("miss_adr", miss_adr, a);
        miss_ack = 1'b1;
        tick();
        miss_ack = 1'b0;
        chk("miss_drop", {127'd0, miss_req}, 128'd0);
    endtask

    task automatic chk_outputs_zero(input string n);
        chk({n, "_rdat"}, rdat, '0);
        chk({n, "_rvalid"}, {127'd0, rvalid}, '0);
        chk({n, "_hit"}, {127'd0, hit}, '0);
        chk({n, "_miss_req"}, {127'd0, miss_req}, '0);
        chk({n, "_miss_adr"}, miss_adr, '0);
    endtask

    initial begin
        rst = 1'b1; wr = 1'b0; inv = 1'b0; inv_all = 1'b0; rd = 1'b0; miss_ack = 1'b0;
        wadr = '0; radr = '0; wdat = '0;
        tick();
        tick();
        rst = 1'b0;
        chk_outputs_zero("reset");

        // Line 2 filled with word index as data, then a hit on word 3
        fill(32'h0000_0800, 128'd0, 0, 63, -1);
        rd_req(32'h0000_0830, 128'd3, 1'b1);
        tick();
        chk("hit_no_miss", {127'd0, miss_req}, 128'd0);

        // Tag miss on line 2, second miss while pending is dropped
        rd_req(32'h0001_0800, 128'd0, 1'b0);
        tick();
        chk("miss_req_1", {127'd0, miss_req}, 128'd1);
        chk("miss_adr_1", miss_adr, 128'h0001_0800);
        rd_req(32'h0002_0800, 128'd0, 1'b0);
        chk("miss_adr_stable", miss_adr, 128'h0001_0800);
        tick();
        chk("miss_req_hold", {127'd0, miss_req}, 128'd1);
        miss_ack = 1'b1;
        tick();
        miss_ack = 1'b0;
        chk("miss_req_acked", {127'd0, miss_req}, 128'd0);
        tick();
        tick();
        chk("second_miss_dropped", {127'd0, miss_req}, 128'd0);

        // Line 3 fill with word 5 skipped stays invalid
        fill(32'h0000_0C00, 128'h300, 0, 63, 5);
        rd_req(32'h0000_0C00, 128'h300, 1'b0);
        ack_miss(32'h0000_0C00);

        // Read of the line being filled raises no refill request
        fill(32'h0000_0C00, 128'h380, 0, 9, -1);
        rd_req(32'h0000_0C20, 128'h382, 1'b0);
        tick();
        chk("fill_no_miss_a", {127'd0, miss_req}, 128'd0);
        tick();
        chk("fill_no_miss_b", {127'd0, miss_req}, 128'd0);
        fill(32'h0000_0C00, 128'h380, 10, 63, -1);
        rd_req(32'h0000_0C00, 128'h380, 1'b1);
        tick();

        // Single-line invalidate
        inv = 1'b1; wadr = 32'h0000_0800;
        tick();
        inv = 1'b0;
        rd_req(32'h0000_0830, 128'd3, 1'b0);
        ack_miss(32'h0000_0800);

        // inv_all on the final beat discards the completion
        fill(32'h0000_0C00, 128'h400, 0, 62, -1);
        wr_beat(32'h0000_0C00 + 32'd16 * 32'd63, 128'h400 + 128'd63, 1'b1);
        rd_req(32'h0000_0C00, 128'h400, 1'b0);
        ack_miss(32'h0000_0C00);

        // Reset in the middle of a fill
        fill(32'h0000_0800, 128'h600, 0, 29, -1);
        rst = 1'b1;
        #2;
        chk_outputs_zero("midfill_rst");
        tick();
        rst = 1'b0;
        fill(32'h0000_0800, 128'h500, 0, 63, -1);
        rd_req(32'h0000_08F0, 128'h50F, 1'b1);
        tick();

        // Back-to-back reads
        for (int i = 0; i < 8; i++) begin
            exp_t e;
            e.d = 128'h500 + 128'(i); e.h = 1'b1;
            q.push_back(e);
            n_reads++;
            rd = 1'b1; radr = 32'h0000_0800 + 32'(16 * i);
            tick();
        end
        rd = 1'b0;
        tick();
        chk("burst_end_rvalid", {127'd0, rvalid}, 128'd0);
        chk("hold_rdat", rdat, 128'h507);
        chk("hold_hit", {127'd0, hit}, 128'd1);

        tick();
        tick();
        chk("rvalid_count", 128'(rv_cnt), 128'(n_reads));
        chk("sb_empty", 128'(q.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mpmc11_strm_read_cache.md
MPMC11_STRM_READ_CACHE -- requirements
Module: mpmc11_strm_read_cache

Interface
REQ-001 SHALL have parameter DW, default 128, meaning data word width in bits (power of 2, >=16).
REQ-002 SHALL have parameter AW, default 32, meaning byte address width.
REQ-003 SHALL have parameter LINES, default 8, meaning number of cache lines (power of 2).
REQ-004 SHALL have parameter BEATS, default 64, meaning words per line (power of 2).
REQ-005 SHALL derive OW=log2(DW/8), BW=log2(BEATS), LW=log2(LINES) and TW=AW-OW-BW-LW; word index SHALL be adr[OW+BW-1:OW], line index adr[OW+BW+LW-1:OW+BW], tag adr[AW-1:OW+BW+LW].
REQ-006 SHALL use one clock and an asynchronous, active-high reset, with ports clk and rst.
REQ-007 Ports, in this order:
  clk  in  1  clock
  rst  in  1  async reset, active high
  wr  in  1  fill write strobe
  wadr  in  AW  fill byte address
  wdat  in  DW  fill data
  inv  in  1  invalidate the line indexed by wadr
  inv_all  in  1  invalidate all lines
  rd  in  1  read strobe
  radr  in  AW  read byte address
  rdat  out  DW  read data
  rvalid  out  1  rdat/hit valid
  hit  out  1  read hit
  miss_req  out  1  line refill request
  miss_adr  out  AW  line-aligned refill address
  miss_ack  in  1  refill request accepted

Function
REQ-008 SHALL write wdat to storage at {line,word} of wadr on every wr, independent of fill state.
REQ-009 SHALL give rd at cycle N a response at N+1: rvalid=1, rdat=stored word, hit=(tag[line]==radr tag) && vbit[line], tag/vbit as registered after edge N; rvalid=0 otherwise; rdat/hit hold when rvalid=0.
REQ-010 SHALL run a fill FSM {IDLE, FILL} with beat counter cnt (BW bits), line register fl and tag register ft.
REQ-011 IDLE: wr with word==0 -> FILL, cnt=1, fl/ft latched, vbit[fl] cleared; other wr ignored.
REQ-012 FILL: wr with line==fl, tag==ft and word==cnt -> cnt+1; when word==BEATS-1, tag[fl]=ft, vbit[fl]=1, -> IDLE.
REQ-013 FILL: any other wr aborts (line remains invalid) and SHALL restart per REQ-011 if that write's word==0, else -> IDLE.
REQ-014 inv SHALL clear vbit[wadr line]; inv_all SHALL clear all vbits; either hitting fl during FILL SHALL abort to IDLE.
REQ-015 Same-cycle priority: inv_all > inv > line-completing write (completion discarded).
REQ-016 Miss FSM {MIDLE, MREQ}: rvalid && !hit in MIDLE -> MREQ, miss_req=1, miss_adr=response address with word and offset bits zero.
REQ-017 SHALL suppress a miss whose line and tag equal fl/ft while FILL is active.
REQ-018 MREQ: hold miss_req/miss_adr stable until miss_ack sampled 1; miss_req=0 the following cycle; misses during MREQ SHALL be dropped, not queued.
REQ-019 miss_ack in MIDLE SHALL be ignored.

Reset
REQ-020 rst SHALL force immediately: vbit all 0, tags 0, fill FSM IDLE, cnt 0, miss FSM MIDLE, rdat 0, rvalid 0, hit 0, miss_req 0, miss_adr 0; storage contents undefined.
REQ-021 rst mid-fill SHALL discard the fill; the next word-0 write starts a fresh fill.

Structure
REQ-022 SHALL place fill-state and miss-state enums and the default parameter constants in mpmc10_pkg.
REQ-023 SHALL instantiate storage as one sub-module mpmc11_strm_cache_ram (single-clock simple dual-port, 1-cycle read latency, LINES*BEATS x DW); tags/vbits SHALL be registers in the parent.

Verification (defaults)
REQ-024 Write words i=0..63 to 0x0000_0800+16*i with data i, then rd 0x0000_0830 -> next cycle rvalid=1, hit=1, rdat=3, miss_req=0.
REQ-025 After REQ-024, rd 0x0001_0800 -> hit=0, miss_req=1, miss_adr=0x0001_0800; miss_ack after 3 cycles -> miss_req=0 next cycle; a second miss while pending produces no request.
REQ-026 Fill line 3 skipping word 5 -> rd 0x0000_0C00 returns hit=0; rd of line 3 during an in-progress fill raises no miss_req.
REQ-027 inv with wadr=0x0000_0800 -> line 2 hit=0; inv_all in the same cycle as the final beat of line 3 -> line 3 hit=0.
REQ-028 Assert rst after 30 beats of a fill -> all outputs 0; a full 64-beat refill then yields hit=1.
REQ-029 rd every cycle for 8 consecutive cycles -> rvalid high for exactly 8 cycles, one cycle late, with data in order.
